// File: rtl/fetch_queue_pkg.sv
// Shared constants for the fetch queue: datapath width, NOP word, PC step
// and the decode read-count encodings.
package fetch_queue_pkg;

  localparam int DW = 32;
  localparam logic [31:0] NOP = 32'h0000_0000;
  localparam logic [31:0] PC_INC = 32'd4;

  localparam logic [1:0] RD_NONE = 2'd0;
  localparam logic [1:0] RD_ONE  = 2'd1;
  localparam logic [1:0] RD_TWO  = 2'd2;

  // Decode may only consume two entries per cycle; encoding 3 means two.
  function automatic logic [1:0] rd_clamp(input logic [1:0] rd);
    return (rd > RD_TWO) ? RD_TWO : rd;
  endfunction

endpackage

// File: rtl/fetch_queue_mem.sv
// DEPTH x {pc, instr} storage: two write ports on consecutive slots,
// two asynchronous read ports and a synchronous clear.
module fetch_queue_mem #(
  parameter int DEPTH = 4,
  parameter int AW    = 2,
  parameter int DW    = 32
) (
  input  logic            reloj,
  input  logic            reset,
  input  logic            we,
  input  logic [AW-1:0]   wr_addr,
  input  logic [2*DW-1:0] wr_data1,
  input  logic [2*DW-1:0] wr_data2,
  input  logic [AW-1:0]   rd_addr1,
  input  logic [AW-1:0]   rd_addr2,
  output logic [2*DW-1:0] rd_data1,
  output logic [2*DW-1:0] rd_data2
);
  import fetch_queue_pkg::*;

  logic [2*DW-1:0] mem_reg [DEPTH];
  logic [AW-1:0]   wr_addr2;

  assign wr_addr2 = wr_addr + AW'(1);

  // Clearing to zero makes every idle read present {0, NOP}.
  always_ff @(posedge reloj) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= {{DW{1'b0}}, NOP[DW-1:0]};
      end
    end else if (we) begin
      mem_reg[wr_addr]  <= wr_data1;
      mem_reg[wr_addr2] <= wr_data2;
    end
  end

  assign rd_data1 = mem_reg[rd_addr1];
  assign rd_data2 = mem_reg[rd_addr2];

endmodule

// File: rtl/fetch_queue.sv
// Two-in/two-out instruction queue between fetch and decode, with
// conservative fetch stall and flush on control-flow redirect.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 2,
  parameter int DW    = 32
) (
  input  logic          reloj,
  input  logic          reset,
  input  logic [DW-1:0] pc_in,
  input  logic [DW-1:0] pc2_in,
  input  logic [DW-1:0] instr1_in,
  input  logic [DW-1:0] instr2_in,
  input  logic          wr_en,
  input  logic          flush,
  input  logic [1:0]    rd_cnt,
  output logic [DW-1:0] instr_d1,
  output logic [DW-1:0] pc_d1,
  output logic          valid_d1,
  output logic [DW-1:0] instr_d2,
  output logic [DW-1:0] pc_d2,
  output logic          valid_d2,
  output logic          stall_fetch,
  output logic [AW:0]   count
);
  import fetch_queue_pkg::*;

  logic [AW-1:0]   rd_ptr_reg, rd_ptr_next;
  logic [AW-1:0]   wr_ptr_reg, wr_ptr_next;
  logic [AW:0]     count_reg, count_next;
  logic [AW:0]     rd_req;
  logic [AW:0]     rd_eff;
  logic            wr_accept;
  logic [2*DW-1:0] rd_data1, rd_data2;

  // Stall looks only at registered occupancy, so rd_cnt never reaches it.
  assign stall_fetch = (count_reg > (AW+1)'(DEPTH - 2));
  assign wr_accept   = wr_en && !stall_fetch && !flush;
  assign rd_req      = (AW+1)'(rd_clamp(rd_cnt));
  assign rd_eff      = (rd_req > count_reg) ? count_reg : rd_req;

  always_comb begin
    rd_ptr_next = rd_ptr_reg;
    wr_ptr_next = wr_ptr_reg;
    count_next  = count_reg;
    if (flush) begin
      rd_ptr_next = wr_ptr_reg;
      count_next  = '0;
    end else begin
      rd_ptr_next = rd_ptr_reg + AW'(rd_eff);
      count_next  = count_reg - rd_eff;
      if (wr_accept) begin
        wr_ptr_next = wr_ptr_reg + AW'(2);
        count_next  = count_next + (AW+1)'(2);
      end
    end
  end

  always_ff @(posedge reloj) begin
    if (reset) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      rd_ptr_reg <= rd_ptr_next;
      wr_ptr_reg <= wr_ptr_next;
      count_reg  <= count_next;
    end
  end

  fetch_queue_mem #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW)
  ) u_mem (
    .reloj    (reloj),
    .reset    (reset),
    .we       (wr_accept),
    .wr_addr  (wr_ptr_reg),
    .wr_data1 ({pc_in, instr1_in}),
    .wr_data2 ({pc2_in, instr2_in}),
    .rd_addr1 (rd_ptr_reg),
    .rd_addr2 (rd_ptr_reg + AW'(1)),
    .rd_data1 (rd_data1),
    .rd_data2 (rd_data2)
  );

  assign pc_d1    = rd_data1[2*DW-1:DW];
  assign instr_d1 = rd_data1[DW-1:0];
  assign pc_d2    = rd_data2[2*DW-1:DW];
  assign instr_d2 = rd_data2[DW-1:0];
  assign valid_d1 = (count_reg >= (AW+1)'(1));
  assign valid_d2 = (count_reg >= (AW+1)'(2));
  assign count    = count_reg;

endmodule
